// File: rtl/fft_mem_sequencer.sv
// fft_mem_sequencer
//   Address/control sequencer for an in-place radix-2 DIT FFT buffer
//   (two read ports, one write port, 2^A_LEN complex words). For each
//   butterfly it drives both read addresses plus the twiddle index and
//   pulses cap. It then waits LAT cycles for the external butterfly
//   datapath and writes both results back in two cycles.
//
//   Parameters: A_LEN (address width, >= 2), LAT (datapath latency, 0..15).
//
//   Ports:
//     clk, rst_n       clock (rising edge), asynchronous active-low reset
//     start            begin a transform; only sampled while idle
//     raddr1, raddr2   read addresses for the upper and lower butterfly legs
//     cap              datapath registers rdata1/rdata2 at the end of this cycle
//     tw_idx           twiddle ROM index for the butterfly being read
//     waddr, we        write address and write strobe
//     wsrc             write-data select: 0 = out A, 1 = out B,
//                      2 = captured rdata1, 3 = captured rdata2
//     busy             high whenever the sequencer is not idle
//     done             one-cycle pulse at transform completion
//
//   Optional feature, enabled by defining FFT_SEQ_BITREV_EN:
//   an in-place bit-reversal pass runs before stage 0. Each index i with
//   i < bitrev(i) costs 3 cycles (read both, write swapped). The next
//   eligible index is found combinationally, so every skipped index costs
//   0 cycles.
//
//   All outputs are registered and describe the state being entered.
module fft_mem_sequencer #(
    parameter int unsigned A_LEN = 5,
    parameter int unsigned LAT   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [A_LEN-1:0] raddr1,
    output logic [A_LEN-1:0] raddr2,
    output logic             cap,
    output logic [A_LEN-2:0] tw_idx,
    output logic [A_LEN-1:0] waddr,
    output logic             we,
    output logic [1:0]       wsrc,
    output logic             busy,
    output logic             done
);

    localparam int unsigned      SW     = $clog2(A_LEN);
    localparam logic [SW-1:0]    S_LAST = SW'(A_LEN - 1);
    localparam logic [A_LEN-2:0] K_LAST = '1;
    localparam logic [3:0]       W_INIT = 4'(LAT - 1);

`ifdef FFT_SEQ_BITREV_EN
    typedef enum logic [3:0] {IDLE, READ, WAIT, WR1, WR2, DONE, BREV, BW1, BW2} state_t;
`else
    typedef enum logic [2:0] {IDLE, READ, WAIT, WR1, WR2, DONE} state_t;
`endif

    state_t           state;
    logic [SW-1:0]    s;
    logic [A_LEN-2:0] k;
    logic [3:0]       wcnt;

    // Mask of the low s bits (half-1 where half = 2^s).
    function automatic logic [A_LEN-1:0] low_mask(input logic [SW-1:0] sv);
        return ~({A_LEN{1'b1}} << sv);
    endfunction

    // Upper leg: insert a zero at bit position s of k.
    function automatic logic [A_LEN-1:0] leg_a1(input logic [A_LEN-2:0] kv,
                                                input logic [SW-1:0]    sv);
        logic [A_LEN-1:0] kk;
        kk = {1'b0, kv};
        return ((kk & ~low_mask(sv)) << 1) | (kk & low_mask(sv));
    endfunction

    function automatic logic [A_LEN-2:0] twiddle(input logic [A_LEN-2:0] kv,
                                                 input logic [SW-1:0]    sv);
        logic [A_LEN-1:0] m;
        m = low_mask(sv);
        return (kv & m[A_LEN-2:0]) << (A_LEN - 1 - int'(sv));
    endfunction

    logic             k_last, s_last;
    logic [A_LEN-2:0] k_adv, adv_tw;
    logic [SW-1:0]    s_adv;
    logic [A_LEN-1:0] cur_a1, cur_a2, adv_a1, adv_a2;

    // Addresses for the current butterfly (writes) and for the one that
    // follows it (reads issued on the WR2 -> READ transition).
    always_comb begin
        k_last = (k == K_LAST);
        s_last = (s == S_LAST);
        k_adv  = k_last ? '0 : k + (A_LEN-1)'(1);
        s_adv  = k_last ? s + SW'(1) : s;
        cur_a1 = leg_a1(k, s);
        cur_a2 = cur_a1 | (A_LEN'(1) << s);
        adv_a1 = leg_a1(k_adv, s_adv);
        adv_a2 = adv_a1 | (A_LEN'(1) << s_adv);
        adv_tw = twiddle(k_adv, s_adv);
    end

`ifdef FFT_SEQ_BITREV_EN
    localparam int unsigned      N       = 1 << A_LEN;
    // bitrev(1) = N/2 > 1 for every legal A_LEN, so index 1 always swaps first.
    localparam logic [A_LEN-1:0] FIRST_I = A_LEN'(1);

    function automatic logic [A_LEN-1:0] bit_rev(input logic [A_LEN-1:0] v);
        logic [A_LEN-1:0] r;
        r = '0;
        for (int unsigned b = 0; b < A_LEN; b++) r[b] = v[A_LEN-1-b];
        return r;
    endfunction

    logic [A_LEN-1:0] bi, nxt_i, cand;
    logic             nxt_found;

    // Smallest index above bi that still needs a swap; scanned from the top
    // so the last hit is the smallest.
    always_comb begin
        nxt_found = 1'b0;
        nxt_i     = '0;
        cand      = '0;
        for (int unsigned j = 0; j < N; j++) begin
            cand = A_LEN'(N - 1 - j);
            if (cand > bi && cand < bit_rev(cand)) begin
                nxt_found = 1'b1;
                nxt_i     = cand;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            s      <= '0;
            k      <= '0;
            wcnt   <= '0;
            raddr1 <= '0;
            raddr2 <= '0;
            tw_idx <= '0;
            waddr  <= '0;
            cap    <= 1'b0;
            we     <= 1'b0;
            wsrc   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef FFT_SEQ_BITREV_EN
            bi     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        s    <= '0;
                        k    <= '0;
                        cap  <= 1'b1;
`ifdef FFT_SEQ_BITREV_EN
                        state  <= BREV;
                        bi     <= FIRST_I;
                        raddr1 <= FIRST_I;
                        raddr2 <= bit_rev(FIRST_I);
`else
                        state  <= READ;
                        raddr1 <= '0;
                        raddr2 <= A_LEN'(1);
                        tw_idx <= '0;
`endif
                    end
                end
                READ: begin
                    cap <= 1'b0;
                    if (LAT > 0) begin
                        state <= WAIT;
                        wcnt  <= W_INIT;
                    end else begin
                        state <= WR1;
                        we    <= 1'b1;
                        waddr <= cur_a1;
                        wsrc  <= 2'd0;
                    end
                end
                WAIT: begin
                    if (wcnt == 4'd0) begin
                        state <= WR1;
                        we    <= 1'b1;
                        waddr <= cur_a1;
                        wsrc  <= 2'd0;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                WR1: begin
                    state <= WR2;
                    waddr <= cur_a2;
                    wsrc  <= 2'd1;
                end
                WR2: begin
                    we <= 1'b0;
                    if (k_last && s_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state  <= READ;
                        k      <= k_adv;
                        s      <= s_adv;
                        cap    <= 1'b1;
                        raddr1 <= adv_a1;
                        raddr2 <= adv_a2;
                        tw_idx <= adv_tw;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
`ifdef FFT_SEQ_BITREV_EN
                BREV: begin
                    state <= BW1;
                    cap   <= 1'b0;
                    we    <= 1'b1;
                    waddr <= bi;
                    wsrc  <= 2'd3;
                end
                BW1: begin
                    state <= BW2;
                    waddr <= bit_rev(bi);
                    wsrc  <= 2'd2;
                end
                BW2: begin
                    we  <= 1'b0;
                    cap <= 1'b1;
                    if (nxt_found) begin
                        state  <= BREV;
                        bi     <= nxt_i;
                        raddr1 <= nxt_i;
                        raddr2 <= bit_rev(nxt_i);
                    end else begin
                        state  <= READ;
                        raddr1 <= '0;
                        raddr2 <= A_LEN'(1);
                        tw_idx <= '0;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_mem_sequencer.sv
module tb_fft_mem_sequencer;

    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start_a, start_b, start_c;

    // DUT A: A_LEN=3, LAT=2
    logic [2:0] a_r1, a_r2, a_wa;
    logic [1:0] a_tw, a_ws;
    logic       a_cap, a_we, a_busy, a_done;
    // DUT B: A_LEN=2, LAT=0
    logic [1:0] b_r1, b_r2, b_wa, b_ws;
    logic [0:0] b_tw;
    logic       b_cap, b_we, b_busy, b_done;
    // DUT C: A_LEN=5, LAT=2
    logic [4:0] c_r1, c_r2, c_wa;
    logic [3:0] c_tw;
    logic [1:0] c_ws;
    logic       c_cap, c_we, c_busy, c_done;

    fft_mem_sequencer #(.A_LEN(3), .LAT(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .raddr1(a_r1), .raddr2(a_r2),
        .cap(a_cap), .tw_idx(a_tw), .waddr(a_wa), .we(a_we), .wsrc(a_ws),
        .busy(a_busy), .done(a_done));
    fft_mem_sequencer #(.A_LEN(2), .LAT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .raddr1(b_r1), .raddr2(b_r2),
        .cap(b_cap), .tw_idx(b_tw), .waddr(b_wa), .we(b_we), .wsrc(b_ws),
        .busy(b_busy), .done(b_done));
    fft_mem_sequencer #(.A_LEN(5), .LAT(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .raddr1(c_r1), .raddr2(c_r2),
        .cap(c_cap), .tw_idx(c_tw), .waddr(c_wa), .we(c_we), .wsrc(c_ws),
        .busy(c_busy), .done(c_done));

    int checks;
    int errors;

    typedef struct { int cap, we, busy, done, r1, r2, tw, wa, ws; } obs_t;
    typedef struct { int cap, we, done, r1, r2, tw, wa, ws, chk_tw; } exp_t;
    exp_t exp_q[$];

    function automatic obs_t observe(input int id);
        obs_t o;
        case (id)
            0: begin
                o.cap = int'(a_cap); o.we = int'(a_we); o.busy = int'(a_busy); o.done = int'(a_done);
                o.r1 = int'(a_r1); o.r2 = int'(a_r2); o.tw = int'(a_tw); o.wa = int'(a_wa); o.ws = int'(a_ws);
            end
            1: begin
                o.cap = int'(b_cap); o.we = int'(b_we); o.busy = int'(b_busy); o.done = int'(b_done);
                o.r1 = int'(b_r1); o.r2 = int'(b_r2); o.tw = int'(b_tw); o.wa = int'(b_wa); o.ws = int'(b_ws);
            end
            default: begin
                o.cap = int'(c_cap); o.we = int'(c_we); o.busy = int'(c_busy); o.done = int'(c_done);
                o.r1 = int'(c_r1); o.r2 = int'(c_r2); o.tw = int'(c_tw); o.wa = int'(c_wa); o.ws = int'(c_ws);
            end
        endcase
        return o;
    endfunction

    task automatic set_start(input int id, input logic v);
        case (id)
            0:       start_a = v;
            1:       start_b = v;
            default: start_c = v;
        endcase
    endtask

    function automatic int bitrev(input int v, input int alen);
        int r = 0;
        for (int b = 0; b < alen; b++) r = (r << 1) | ((v >> b) & 1);
        return r;
    endfunction

    function automatic exp_t mk(input int cap, we, dn, r1, r2, tw, wa, ws, chk);
        exp_t e;
        e.cap = cap; e.we = we; e.done = dn; e.r1 = r1; e.r2 = r2;
        e.tw = tw; e.wa = wa; e.ws = ws; e.chk_tw = chk;
        return e;
    endfunction

    function automatic int swap_count(input int alen);
        int c = 0;
`ifdef FFT_SEQ_BITREV_EN
        for (int i = 0; i < (1 << alen); i++) if (i < bitrev(i, alen)) c++;
`endif
        return c;
    endfunction

    // Cycle-by-cycle expected trace, built from the textbook in-place DIT loop
    // nest (stage / group / offset within group).
    task automatic build_expected(input int alen, input int lat);
        int n = 1 << alen;
        exp_q.delete();
`ifdef FFT_SEQ_BITREV_EN
        for (int i = 0; i < n; i++) begin
            int r = bitrev(i, alen);
            if (i < r) begin
                exp_q.push_back(mk(1, 0, 0, i, r, 0, 0, 0, 0));
                exp_q.push_back(mk(0, 1, 0, 0, 0, 0, i, 3, 0));
                exp_q.push_back(mk(0, 1, 0, 0, 0, 0, r, 2, 0));
            end
        end
`endif
        for (int half = 1; half < n; half *= 2)
            for (int base = 0; base < n; base += 2 * half)
                for (int j = 0; j < half; j++) begin
                    exp_q.push_back(mk(1, 0, 0, base + j, base + j + half, j * (n / (2 * half)), 0, 0, 1));
                    for (int w = 0; w < lat; w++) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
                    exp_q.push_back(mk(0, 1, 0, 0, 0, 0, base + j, 0, 0));
                    exp_q.push_back(mk(0, 1, 0, 0, 0, 0, base + j + half, 1, 0));
                end
        exp_q.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
    endtask

    // mode 0: start pulsed; 1: random start noise while busy; 2: start held high
    task automatic test_trace(input int id, input int alen, input int lat, input int mode, input string name);
        obs_t o;
        exp_t e;
        int   n_rec;
        build_expected(alen, lat);
        n_rec = exp_q.size();
        @(negedge clk); set_start(id, 1'b1);
        for (int c = 0; c < n_rec; c++) begin
            @(negedge clk);
            o = observe(id);
            e = exp_q[c];
            checks++; if (o.cap !== e.cap) begin errors++; $display("FAIL %s[%0d] cap: got %0d expected %0d", name, c, o.cap, e.cap); end
            checks++; if (o.we !== e.we) begin errors++; $display("FAIL %s[%0d] we: got %0d expected %0d", name, c, o.we, e.we); end
            checks++; if (o.done !== e.done) begin errors++; $display("FAIL %s[%0d] done: got %0d expected %0d", name, c, o.done, e.done); end
            checks++; if (o.busy !== 1) begin errors++; $display("FAIL %s[%0d] busy: got %0d expected 1", name, c, o.busy); end
            if (e.cap == 1) begin
                checks++; if (o.r1 !== e.r1 || o.r2 !== e.r2) begin errors++; $display("FAIL %s[%0d] raddr: got (%0d,%0d) expected (%0d,%0d)", name, c, o.r1, o.r2, e.r1, e.r2); end
                if (e.chk_tw == 1) begin
                    checks++; if (o.tw !== e.tw) begin errors++; $display("FAIL %s[%0d] tw_idx: got %0d expected %0d", name, c, o.tw, e.tw); end
                end
            end
            if (e.we == 1) begin
                checks++; if (o.wa !== e.wa || o.ws !== e.ws) begin errors++; $display("FAIL %s[%0d] write: got waddr=%0d wsrc=%0d expected waddr=%0d wsrc=%0d", name, c, o.wa, o.ws, e.wa, e.ws); end
            end
            if (mode == 2) set_start(id, 1'b1);
            else if (mode == 1 && c < n_rec - 1) set_start(id, 1'($urandom_range(0, 1)));
            else set_start(id, 1'b0);
        end
        @(negedge clk);
        o = observe(id);
        checks++; if (o.busy !== 0 || o.done !== 0 || o.cap !== 0 || o.we !== 0) begin errors++; $display("FAIL %s idle_after_done: got busy=%0d done=%0d cap=%0d we=%0d expected all 0", name, o.busy, o.done, o.cap, o.we); end
        if (mode == 2) begin
            // start was held through DONE: the single idle cycle must launch a new run
            @(negedge clk);
            set_start(id, 1'b0);
            o = observe(id);
            checks++; if (o.busy !== 1 || o.cap !== 1 || o.r1 !== exp_q[0].r1 || o.r2 !== exp_q[0].r2) begin errors++; $display("FAIL %s restart: got busy=%0d cap=%0d raddr=(%0d,%0d) expected busy=1 cap=1 raddr=(%0d,%0d)", name, o.busy, o.cap, o.r1, o.r2, exp_q[0].r1, exp_q[0].r2); end
            begin
                int cyc = 0;
                while (observe(id).done !== 1 && cyc < 2000) begin @(negedge clk); cyc++; end
                checks++; if (cyc >= 2000) begin errors++; $display("FAIL %s restart_done: timeout after %0d cycles", name, cyc); end
            end
            @(negedge clk);
        end else begin
            @(negedge clk);
            o = observe(id);
            checks++; if (o.busy !== 0) begin errors++; $display("FAIL %s stays_idle: got busy=%0d expected 0", name, o.busy); end
        end
    endtask

    task automatic test_reset();
        obs_t o;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        for (int id = 0; id < 3; id++) begin
            o = observe(id);
            checks++;
            if ((o.cap | o.we | o.busy | o.done | o.r1 | o.r2 | o.tw | o.wa | o.ws) !== 0) begin
                errors++;
                $display("FAIL reset_state dut%0d: got cap=%0d we=%0d busy=%0d done=%0d r1=%0d r2=%0d tw=%0d wa=%0d ws=%0d expected all 0",
                         id, o.cap, o.we, o.busy, o.done, o.r1, o.r2, o.tw, o.wa, o.ws);
            end
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        obs_t o;
        int   stage0 = swap_count(3) * 3 + 4 * 5;
        @(negedge clk); start_a = 1'b1;
        for (int c = 0; c < stage0 + 7; c++) begin
            @(negedge clk);
            start_a = 1'($urandom_range(0, 1));
        end
        start_a = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        o = observe(0);
        checks++;
        if ((o.cap | o.we | o.busy | o.done | o.r1 | o.r2 | o.tw | o.wa | o.ws) !== 0) begin
            errors++;
            $display("FAIL midrun_async_reset: got cap=%0d we=%0d busy=%0d done=%0d r1=%0d r2=%0d tw=%0d wa=%0d ws=%0d expected all 0",
                     o.cap, o.we, o.busy, o.done, o.r1, o.r2, o.tw, o.wa, o.ws);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            o = observe(0);
            checks++; if (o.done !== 0 || o.busy !== 0) begin errors++; $display("FAIL midrun_no_done[%0d]: got done=%0d busy=%0d expected 0 0", c, o.done, o.busy); end
        end
        test_trace(0, 3, 2, 0, "a_after_reset");
    endtask

    // Memory and butterfly datapath model for DUT C (LAT latency is implicit:
    // results are computed at capture and held until the writes).
    real mre[32], mim[32];
    real d1r, d1i, d2r, d2i, tr, ti, ang, oar, oai, obr, obi;
    always @(negedge clk) begin
        if (c_cap === 1'b1) begin
            d1r = mre[c_r1]; d1i = mim[c_r1];
            d2r = mre[c_r2]; d2i = mim[c_r2];
            ang = 2.0 * PI * real'(int'(c_tw)) / 32.0;
            tr  = d2r * $cos(ang) + d2i * $sin(ang);
            ti  = d2i * $cos(ang) - d2r * $sin(ang);
            oar = d1r + tr; oai = d1i + ti;
            obr = d1r - tr; obi = d1i - ti;
        end
        if (c_we === 1'b1) begin
            case (c_ws)
                2'd0: begin mre[c_wa] = oar; mim[c_wa] = oai; end
                2'd1: begin mre[c_wa] = obr; mim[c_wa] = obi; end
                2'd2: begin mre[c_wa] = d1r; mim[c_wa] = d1i; end
                default: begin mre[c_wa] = d2r; mim[c_wa] = d2i; end
            endcase
        end
    end

    task automatic test_fft();
        real xr[32], xi[32];
        int  cyc = 0;
        for (int n = 0; n < 32; n++) begin
            xr[n] = (real'(int'($urandom_range(0, 2000))) - 1000.0) / 1000.0;
            xi[n] = (real'(int'($urandom_range(0, 2000))) - 1000.0) / 1000.0;
`ifdef FFT_SEQ_BITREV_EN
            mre[n] = xr[n]; mim[n] = xi[n];
`else
            mre[bitrev(n, 5)] = xr[n]; mim[bitrev(n, 5)] = xi[n];
`endif
        end
        @(negedge clk); start_c = 1'b1;
        @(negedge clk); start_c = 1'b0;
        while (c_done !== 1'b1 && cyc < 5000) begin @(negedge clk); cyc++; end
        checks++; if (cyc >= 5000) begin errors++; $display("FAIL fft_done: timeout after %0d cycles", cyc); end
        @(negedge clk);
        for (int kf = 0; kf < 32; kf++) begin
            real sr = 0.0, si = 0.0, a, dr, di;
            for (int n = 0; n < 32; n++) begin
                a  = 2.0 * PI * real'(kf * n) / 32.0;
                sr = sr + xr[n] * $cos(a) + xi[n] * $sin(a);
                si = si + xi[n] * $cos(a) - xr[n] * $sin(a);
            end
            dr = mre[kf] - sr;
            di = mim[kf] - si;
            checks++;
            if (dr > 1.0e-6 || dr < -1.0e-6 || di > 1.0e-6 || di < -1.0e-6) begin
                errors++;
                $display("FAIL fft_bin[%0d]: got (%f,%f) expected (%f,%f)", kf, mre[kf], mim[kf], sr, si);
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        rst_n   = 1'b1;
        test_reset();
        test_trace(0, 3, 2, 0, "a_sequence");
        test_trace(0, 3, 2, 1, "a_start_while_busy");
        test_trace(1, 2, 0, 1, "b_lat0");
        test_trace(1, 2, 0, 2, "b_back_to_back");
        test_reset_midrun();
        test_fft();
        test_trace(2, 5, 2, 1, "c_sequence");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
